uart_stream: RTL and testbench

- Parametrised full-duplex UART core; successor to the fixed 8N1 uart_top.
- Configurable data width, parity mode and stop-bit count.
- Valid/ready byte streams toward the fabric and raw tx_phy/rx_phy pins toward the board.
- Reports per-frame parity and framing errors and receive overrun; sits directly under the board-level wrapper.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_engine.sv | 101 ++++++++++
 rtl/uart_stream.sv | 110 +++++++++++
 tb/tb_uart_stream.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, FSM encodings and the parity helper
// shared by the uart_stream TX path and its RX engine.
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_PARITY    = 3'd3;
  localparam logic [2:0] RX_STOP      = 3'd4;
  localparam logic [2:0] RX_WAIT_IDLE = 3'd5;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(
    input logic [7:0] data,
    input int         mode
  );
    parity_bit = (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction
endpackage

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: input synchroniser, mid-bit sampling receive FSM
// and the held output word with overrun detection.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1085,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_phy,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);

  logic                 sync1, sync2;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_rx;
  logic                 tick, done, perr;

  assign tick = (cnt == FULL);
  assign done = (state == RX_STOP) && tick;
  assign perr = (PARITY != PARITY_NONE) &&
                (par_rx != parity_bit(8'(shreg), PARITY));
  assign rx_busy = (state != RX_IDLE) && (state != RX_WAIT_IDLE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync2, sync1} <= 2'b11;
    else        {sync2, sync1} <= {sync1, rx_phy};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= RX_IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      par_rx <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      unique case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!sync2) state <= RX_START;
        end
        RX_START: if (cnt == HALF) begin
          cnt   <= '0;
          idx   <= '0;
          state <= sync2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (tick) begin
          shreg <= {sync2, shreg[DATA_BITS-1:1]};
          idx   <= idx + 3'd1;
          if (idx == LAST)
            state <= (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
        end
        RX_PARITY: if (tick) begin
          par_rx <= sync2;
          state  <= RX_STOP;
        end
        // A low stop bit means a break; hold off until the line recovers.
        RX_STOP: if (tick) state <= sync2 ? RX_IDLE : RX_WAIT_IDLE;
        RX_WAIT_IDLE: if (sync2) state <= RX_IDLE;
        default: state <= RX_IDLE;
      endcase
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_parity_err <= 1'b0;
      m_frame_err  <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (done) begin
        if (!m_valid || m_ready) begin
          m_valid      <= 1'b1;
          m_data       <= shreg;
          m_parity_err <= perr;
          m_frame_err  <= !sync2;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
endmodule

// File: rtl/uart_stream.sv
// uart_stream: parametrised full-duplex UART with valid/ready byte
// streams; TX engine inline, RX engine in uart_rx_engine.
module uart_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1085,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 tx_phy,
  output logic                 tx_busy,
  input  logic                 rx_phy,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0] SLAST = 3'(STOP_BITS - 1);

  logic [2:0]           tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [2:0]           tx_idx;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic                 tx_tick;

  assign s_ready = (tx_state == TX_IDLE);
  assign tx_busy = !s_ready;
  assign tx_tick = (tx_cnt == FULL);

  // tx_phy is registered so the pin never glitches between bits.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_phy   <= 1'b1;
    end else begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + CW'(1);
      unique case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          tx_idx <= '0;
          if (s_valid) begin
            tx_state <= TX_START;
            tx_sh    <= s_data;
            tx_par   <= parity_bit(8'(s_data), PARITY);
            tx_phy   <= 1'b0;
          end
        end
        TX_START: if (tx_tick) begin
          tx_state <= TX_DATA;
          tx_phy   <= tx_sh[0];
        end
        TX_DATA: if (tx_tick) begin
          tx_idx <= tx_idx + 3'd1;
          tx_sh  <= tx_sh >> 1;
          tx_phy <= tx_sh[1];
          if (tx_idx == LAST) begin
            tx_idx   <= '0;
            tx_state <= (PARITY == PARITY_NONE) ? TX_STOP : TX_PARITY;
            tx_phy   <= (PARITY == PARITY_NONE) ? 1'b1 : tx_par;
          end
        end
        TX_PARITY: if (tx_tick) begin
          tx_state <= TX_STOP;
          tx_phy   <= 1'b1;
        end
        TX_STOP: if (tx_tick) begin
          tx_idx <= tx_idx + 3'd1;
          if (tx_idx == SLAST) tx_state <= TX_IDLE;
        end
        default: begin
          tx_state <= TX_IDLE;
          tx_phy   <= 1'b1;
        end
      endcase
    end

  uart_rx_engine #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS),
    .PARITY      (PARITY)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_phy      (rx_phy),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_parity_err(m_parity_err),
    .m_frame_err (m_frame_err),
    .rx_overrun  (rx_overrun),
    .rx_busy     (rx_busy)
  );
endmodule

// File: tb/tb_uart_stream.sv
// tb_uart_stream: three uart_stream configs (8N1, even loopback,
// odd with two stops) against a frame-level reference model.
module tb_uart_stream;
  localparam int CPB = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] s_valid = 3'b000;
  logic [2:0] m_ready = 3'b111;
  logic [7:0] s_data [3];
  logic [7:0] m_data [3];
  logic [2:0] s_ready, tx_phy, tx_busy, m_valid;
  logic [2:0] m_perr, m_ferr, ovr, rx_busy;
  logic       rx_a = 1'b1;
  logic       rx_c = 1'b1;
  int         total = 0;
  int         bad = 0;
  int         ovr_cnt [3] = '{0, 0, 0};
  rx_t        q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  uart_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .tx_phy(tx_phy[0]), .tx_busy(tx_busy[0]),
    .rx_phy(rx_a), .m_data(m_data[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready[0]), .m_parity_err(m_perr[0]),
    .m_frame_err(m_ferr[0]), .rx_overrun(ovr[0]), .rx_busy(rx_busy[0]));

  uart_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2),
                .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .tx_phy(tx_phy[1]), .tx_busy(tx_busy[1]),
    .rx_phy(tx_phy[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready[1]), .m_parity_err(m_perr[1]),
    .m_frame_err(m_ferr[1]), .rx_overrun(ovr[1]), .rx_busy(rx_busy[1]));

  uart_stream #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1),
                .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[2]), .s_valid(s_valid[2]),
    .s_ready(s_ready[2]), .tx_phy(tx_phy[2]), .tx_busy(tx_busy[2]),
    .rx_phy(rx_c), .m_data(m_data[2]), .m_valid(m_valid[2]),
    .m_ready(m_ready[2]), .m_parity_err(m_perr[2]),
    .m_frame_err(m_ferr[2]), .rx_overrun(ovr[2]), .rx_busy(rx_busy[2]));

  always begin
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      if (rst_n && ovr[k]) ovr_cnt[k]++;
    if (m_valid[0] && m_ready[0]) q0.push_back({m_data[0], m_perr[0], m_ferr[0]});
    if (m_valid[1] && m_ready[1]) q1.push_back({m_data[1], m_perr[1], m_ferr[1]});
    if (m_valid[2] && m_ready[2]) q2.push_back({m_data[2], m_perr[2], m_ferr[2]});
  end

  function automatic int pm(input int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : 0;
  endfunction

  function automatic int flen(input int k);
    return 9 + ((pm(k) != 0) ? 1 : 0) + ((k == 2) ? 2 : 1);
  endfunction

  // Line levels of one frame, bit 0 first; unused tail stays high.
  function automatic logic [15:0] frame(input int k, input logic [7:0] d,
                                        input logic flip);
    logic [15:0] f;
    logic        odd_ones;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    odd_ones = ($countones(d) % 2) == 1;
    if (pm(k) != 0) f[9] = (odd_ones == (pm(k) == 2)) ^ flip;
    return f;
  endfunction

  function automatic int qsize(input int k);
    if (k == 0) return q0.size();
    if (k == 1) return q1.size();
    return q2.size();
  endfunction

  task automatic qpop(input int k, output rx_t r);
    r = '0;
    if (k == 0 && q0.size() > 0) r = q0.pop_front();
    if (k == 1 && q1.size() > 0) r = q1.pop_front();
    if (k == 2 && q2.size() > 0) r = q2.pop_front();
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int k, input logic v);
    if (k == 0) rx_a = v;
    else rx_c = v;
  endtask

  task automatic drive_rx(input int k, input logic [15:0] f, input int len);
    for (int b = 0; b < len; b++) begin
      set_rx(k, f[b]);
      cyc(CPB);
    end
    set_rx(k, 1'b1);
  endtask

  task automatic send_check(input int k, input logic [7:0] d, input logic hold);
    logic [15:0] f;
    int          n, ephy, ebusy, at;
    logic        got;
    f = frame(k, d, 1'b0);
    n = flen(k) * CPB;
    ephy = 0; ebusy = 0; at = 0; got = 1'b0;
    s_data[k] = d;
    s_valid[k] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (!hold) s_valid[k] = 1'b0;
        total++;
        if (s_ready[k] !== 1'b0) begin
          bad++;
          $display("FAIL s_ready_drop inst=%0d got=%b want=0", k, s_ready[k]);
        end
      end
      if (tx_phy[k] !== f[i/CPB]) begin
        if (ephy == 0) begin at = i; got = tx_phy[k]; end
        ephy++;
      end
      if (tx_busy[k] !== 1'b1) ebusy++;
    end
    total++;
    if (ephy != 0) begin
      bad++;
      $display("FAIL tx_phy inst=%0d data=%h cycle=%0d got=%b want=%b",
               k, d, at, got, f[at/CPB]);
    end
    total++;
    if (ebusy != 0) begin
      bad++;
      $display("FAIL tx_busy inst=%0d data=%h low_cycles=%0d want=0", k, d, ebusy);
    end
    @(negedge clk);
    total++;
    if ({tx_busy[k], s_ready[k]} !== 2'b01) begin
      bad++;
      $display("FAIL tx_done inst=%0d got busy,ready=%b%b want=01",
               k, tx_busy[k], s_ready[k]);
    end
  endtask

  task automatic expect_rx(input int k, input string name, input rx_t want);
    rx_t r;
    total++;
    if (qsize(k) != 1) begin
      bad++;
      $display("FAIL %s_count inst=%0d got=%0d want=1", name, k, qsize(k));
    end
    qpop(k, r);
    total++;
    if (r !== want) begin
      bad++;
      $display("FAIL %s inst=%0d got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b",
               name, k, r.d, r.pe, r.fe, want.d, want.pe, want.fe);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({tx_phy[k], s_ready[k], tx_busy[k], m_valid[k], m_data[k],
           m_perr[k], m_ferr[k], ovr[k], rx_busy[k]} !== 16'b1100_0000_0000_0000) begin
        bad++;
        $display("FAIL reset_state inst=%0d got=%b%b%b%b_%h_%b%b%b%b want=1100_00_0000",
                 k, tx_phy[k], s_ready[k], tx_busy[k], m_valid[k], m_data[k],
                 m_perr[k], m_ferr[k], ovr[k], rx_busy[k]);
      end
    end
    rst_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_tx();
    send_check(0, 8'h55, 1'b0);
    for (int i = 0; i < 3; i++) send_check(0, 8'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) send_check(2, 8'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] list[$];
    list = '{8'hA5, 8'h3C};
    for (int i = 0; i < 3; i++) list.push_back(8'($urandom));
    q1.delete();
    for (int i = 0; i < list.size(); i++)
      send_check(1, list[i], i != list.size() - 1);
    cyc(10);
    total++;
    if (qsize(1) != list.size()) begin
      bad++;
      $display("FAIL loop_count got=%0d want=%0d", qsize(1), list.size());
    end
    for (int i = 0; i < list.size(); i++) begin
      rx_t r;
      qpop(1, r);
      total++;
      if (r !== {list[i], 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL loop_word idx=%0d got d=%h pe=%b fe=%b want d=%h pe=0 fe=0",
                 i, r.d, r.pe, r.fe, list[i]);
      end
    end
  endtask

  task automatic test_rx_random();
    logic [7:0] d;
    logic       flip;
    q0.delete();
    q2.delete();
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      drive_rx(0, frame(0, d, 1'b0), flen(0));
      cyc(CPB);
      expect_rx(0, "rx8n1", {d, 1'b0, 1'b0});
    end
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      flip = 1'($urandom);
      drive_rx(2, frame(2, d, flip), flen(2));
      cyc(CPB);
      expect_rx(2, "rx_odd", {d, flip, 1'b0});
    end
  endtask

  task automatic test_parity_err();
    q2.delete();
    drive_rx(2, frame(2, 8'h01, 1'b1), flen(2));
    cyc(CPB);
    expect_rx(2, "par_bad", {8'h01, 1'b1, 1'b0});
    drive_rx(2, frame(2, 8'h01, 1'b0), flen(2));
    cyc(CPB);
    expect_rx(2, "par_good", {8'h01, 1'b0, 1'b0});
  endtask

  task automatic test_frame_err();
    logic [15:0] f;
    q0.delete();
    f = frame(0, 8'h7E, 1'b0);
    f[9] = 1'b0;
    for (int b = 0; b < 10; b++) begin
      rx_a = f[b];
      cyc(CPB);
    end
    cyc(20 * CPB);
    total++;
    if (rx_busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL break_busy got=%b want=0", rx_busy[0]);
    end
    rx_a = 1'b1;
    cyc(3 * CPB);
    expect_rx(0, "frame_err", {8'h7E, 1'b0, 1'b1});
    drive_rx(0, frame(0, 8'hC3, 1'b0), flen(0));
    cyc(CPB);
    expect_rx(0, "after_break", {8'hC3, 1'b0, 1'b0});
  endtask

  task automatic test_overrun();
    int base;
    q0.delete();
    base = ovr_cnt[0];
    m_ready[0] = 1'b0;
    drive_rx(0, frame(0, 8'h11, 1'b0), flen(0));
    cyc(CPB);
    drive_rx(0, frame(0, 8'h22, 1'b0), flen(0));
    cyc(CPB);
    total++;
    if ({m_valid[0], m_data[0]} !== {1'b1, 8'h11}) begin
      bad++;
      $display("FAIL ovr_hold got v=%b d=%h want v=1 d=11", m_valid[0], m_data[0]);
    end
    total++;
    if (ovr_cnt[0] - base != 1) begin
      bad++;
      $display("FAIL ovr_pulse got=%0d want=1", ovr_cnt[0] - base);
    end
    m_ready[0] = 1'b1;
    cyc(1);
    m_ready[0] = 1'b0;
    cyc(1);
    expect_rx(0, "ovr_word", {8'h11, 1'b0, 1'b0});
    base = ovr_cnt[0];
    drive_rx(0, frame(0, 8'h11, 1'b0), flen(0));
    cyc(CPB);
    // Stop bit is sampled at the 41st edge after the start bit is driven.
    fork
      drive_rx(0, frame(0, 8'h22, 1'b0), flen(0));
      begin
        cyc(40);
        m_ready[0] = 1'b1;
        cyc(1);
        m_ready[0] = 1'b0;
      end
    join
    cyc(2);
    total++;
    if ({m_valid[0], m_data[0]} !== {1'b1, 8'h22}) begin
      bad++;
      $display("FAIL same_cycle got v=%b d=%h want v=1 d=22", m_valid[0], m_data[0]);
    end
    total++;
    if (ovr_cnt[0] != base) begin
      bad++;
      $display("FAIL same_cycle_ovr got=%0d want=0", ovr_cnt[0] - base);
    end
    expect_rx(0, "same_cycle_word", {8'h11, 1'b0, 1'b0});
    m_ready[0] = 1'b1;
    cyc(2);
    q0.delete();
  endtask

  task automatic test_glitch();
    logic seen;
    q0.delete();
    seen = 1'b0;
    for (int t = 0; t < 3; t++) begin
      rx_a = 1'b0;
      cyc($urandom_range(1, CPB / 2));
      rx_a = 1'b1;
      for (int i = 0; i < 12 * CPB; i++) begin
        @(negedge clk);
        if (rx_busy[0]) seen = 1'b1;
      end
    end
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL glitch_detect got=%b want=1", seen);
    end
    total++;
    if (qsize(0) != 0 || rx_busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL glitch_out got frames=%0d busy=%b want 0 0", qsize(0), rx_busy[0]);
    end
  endtask

  task automatic test_reset_mid();
    q0.delete();
    s_data[0] = 8'($urandom);
    s_valid[0] = 1'b1;
    cyc(1);
    s_valid[0] = 1'b0;
    rx_a = 1'b0;
    cyc(12);
    rx_a = 1'b1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({tx_phy[0], s_ready[0], tx_busy[0], rx_busy[0]} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_mid got phy,ready,tbusy,rbusy=%b%b%b%b want=1100",
               tx_phy[0], s_ready[0], tx_busy[0], rx_busy[0]);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(12 * CPB);
    total++;
    if (qsize(0) != 0 || tx_phy[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset_abort got frames=%0d phy=%b want 0 1", qsize(0), tx_phy[0]);
    end
    send_check(0, 8'($urandom), 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) s_data[k] = 8'h00;
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx_random();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
